cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Parametrised multi-cycle control sequencer for the nemesys core; next generation of the core's
//  free-running 2-bit FETCH/DECODE/EXECUTE/WRITE_BACK stepper. Adds an instruction-memory
//  req/ack handshake with timeout, variable-latency execute, HALT and FAULT states, and
//  retirement/cycle counters. Sits between instr_mem, decode, ALU/multi-cycle units, regbank, pc_cntrl.
// PARAMETERS
//  WIDTH        32   instruction/data width
//  CNT_W        32   width of cycle_count and retired_count
//  TIMEOUT      15   max cycles FETCH waits for imem_ack before FAULT (>=1)
//  EXEC_MAX     255  max cycles EXECUTE waits for exec_done before FAULT (>=1)
// PORTS
//  clk            in   1      clock; all state changes on posedge
//  reset          in   1      synchronous, active-high
//  imem_req       out  1      fetch request to instr_mem
//  imem_ack       in   1      instr_mem has valid imem_rdata this cycle
//  imem_rdata     in   WIDTH  fetched instruction
//  inst           out  WIDTH  latched instruction, stable DECODE..WRITE_BACK
//  dec_multicycle in   1      decoded inst needs exec_done handshake
//  dec_writes_reg in   1      decoded inst writes regbank
//  dec_is_halt    in   1      decoded inst is HALT
//  exec_start     out  1      one-cycle pulse launching multi-cycle unit
//  exec_done      in   1      multi-cycle unit finished
//  reg_write_en   out  1      regbank write strobe
//  pc_enable      out  1      pc_cntrl advance/branch strobe
//  state          out  3      current state (encoding from shared defines)
//  halted         out  1      core stopped at HALT
//  fault          out  1      core stopped on timeout
//  cycle_count    out  CNT_W  cycles since reset while not halted/faulted
//  retired_count  out  CNT_W  instructions completed WRITE_BACK
// BEHAVIOUR
//  Reset: state=FETCH, inst=0, all strobes 0, halted=fault=0, both counters 0; reset wins over all.
//  FETCH: imem_req=1. On imem_ack: inst<=imem_rdata, ->DECODE. Wait counter increments per cycle
//   without ack; reaching TIMEOUT with no ack -> FAULT. Ack on the TIMEOUT-th cycle is accepted.
//  DECODE (1 cycle): dec_is_halt -> HALT (pc not advanced, not retired); else dec_multicycle ->
//   EXECUTE with exec_start=1 in the DECODE->EXECUTE cycle only; else -> EXECUTE, no start.
//  EXECUTE: single-cycle inst: 1 cycle then WRITE_BACK. Multi-cycle: hold until exec_done, then
//   WRITE_BACK; exec_done in first EXECUTE cycle allowed; exec_done outside EXECUTE ignored.
//   EXEC_MAX cycles without exec_done -> FAULT.
//  WRITE_BACK (1 cycle): pc_enable=1; reg_write_en=dec_writes_reg; retired_count+=1; ->FETCH.
//  HALT, FAULT: terminal until reset; imem_req, exec_start, strobes 0; halted/fault held 1.
//  Strobes are registered-state decodes (Moore): valid in the cycle state equals the stage.
//  Counters wrap modulo 2^CNT_W; cycle_count stops incrementing in HALT/FAULT.
//  Minimum instruction latency with imem_ack immediate: 4 cycles (FETCH,DECODE,EXECUTE,WB).
//  Wait counters clear on every state change; widths sized by $clog2(TIMEOUT+1)/$clog2(EXEC_MAX+1).
// STRUCTURE
//  defines.vh: 3-bit state codes FETCH=0, DECODE=1, EXECUTE=2, WRITE_BACK=3, HALT=4, FAULT=5
//   (replacing the 2-bit codes); core's `WIDTH reused as WIDTH default.
//  One sub-module: cpu_perf_counter (CNT_W, inc, clear) instanced twice for cycle/retired counts.
//  Single always block for state register; outputs decoded combinationally from state.
// TESTING
//  ack immediate, 3 non-halt single-cycle insts -> each 4 cycles, retired_count=3 at cycle 12.
//  imem_ack delayed 5 cycles (TIMEOUT=15) -> imem_req held 6 cycles, inst latched on ack cycle.
//  no ack for 15 cycles -> FAULT on cycle 16, fault=1, cycle_count frozen, retired_count unchanged.
//  multi-cycle inst, exec_done after 7 cycles -> exactly one exec_start pulse, WB on 8th cycle.
//  dec_is_halt after 2 retired insts -> HALT, halted=1, pc_enable never pulses for HALT.
//  reset asserted mid-EXECUTE multi-cycle -> next cycle state=FETCH, counters 0, no reg_write_en.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared state codes and helpers for the nemesys multi-cycle control sequencer.
package cpu_sequencer_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_WRITE_BACK = 3'd3,
    ST_HALT       = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  function automatic logic is_stopped(input state_t s);
    return (s == ST_HALT) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/cpu_perf_counter.sv
// Free-running wrap-around event counter; increments one cycle after i_inc,
// synchronous clear has priority. No backpressure.
module cpu_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXECUTE/WRITE_BACK sequencer, >=4 cycles per instruction; stalls on
// imem_ack and exec_done with bounded waits that end in FAULT. Strobes are Moore decodes.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 15,
  parameter int EXEC_MAX = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic [WIDTH-1:0] o_inst,
  input  logic             i_dec_multicycle,
  input  logic             i_dec_writes_reg,
  input  logic             i_dec_is_halt,
  output logic             o_exec_start,
  input  logic             i_exec_done,
  output logic             o_reg_write_en,
  output logic             o_pc_enable,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_retired_count
);

  localparam int FW = $clog2(TIMEOUT + 1);
  localparam int EW = $clog2(EXEC_MAX + 1);
  localparam logic [FW-1:0] FETCH_LAST = FW'(TIMEOUT - 1);
  localparam logic [EW-1:0] EXEC_LAST  = EW'(EXEC_MAX - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_inst;
  logic             r_multi;
  logic [FW-1:0]    r_fetch_cnt;
  logic [EW-1:0]    r_exec_cnt;
  logic             w_cyc_inc;
  logic             w_ret_inc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_FETCH;
      r_inst      <= '0;
      r_multi     <= 1'b0;
      r_fetch_cnt <= '0;
      r_exec_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && i_imem_ack) begin
        r_inst <= i_imem_rdata;
      end
      if (r_state == ST_DECODE) begin
        r_multi <= i_dec_multicycle;
      end
      // Wait counters only run while the state is held; any transition clears them.
      r_fetch_cnt <= (r_state == ST_FETCH && w_next == ST_FETCH) ? r_fetch_cnt + 1'b1 : '0;
      r_exec_cnt  <= (r_state == ST_EXECUTE && w_next == ST_EXECUTE) ? r_exec_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next         = r_state;
    o_imem_req     = 1'b0;
    o_exec_start   = 1'b0;
    o_reg_write_en = 1'b0;
    o_pc_enable    = 1'b0;
    o_halted       = 1'b0;
    o_fault        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_next = ST_DECODE;
        end else if (r_fetch_cnt == FETCH_LAST) begin
          w_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        o_exec_start = i_dec_multicycle && !i_dec_is_halt;
        w_next       = i_dec_is_halt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (!r_multi || i_exec_done) begin
          w_next = ST_WRITE_BACK;
        end else if (r_exec_cnt == EXEC_LAST) begin
          w_next = ST_FAULT;
        end
      end
      ST_WRITE_BACK: begin
        o_pc_enable    = 1'b1;
        o_reg_write_en = i_dec_writes_reg;
        w_next         = ST_FETCH;
      end
      ST_HALT:  o_halted = 1'b1;
      ST_FAULT: o_fault  = 1'b1;
      default:  w_next   = ST_FAULT;
    endcase
  end

  assign w_cyc_inc = !is_stopped(r_state);
  assign w_ret_inc = (r_state == ST_WRITE_BACK);
  assign o_inst    = r_inst;
  assign o_state   = r_state;

  cpu_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_inc   (w_cyc_inc),
    .o_count (o_cycle_count)
  );

  cpu_perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_inc   (w_ret_inc),
    .o_count (o_retired_count)
  );

endmodule
